// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and defaults for the RAM access arbiter
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam int          ADDR_W   = 8;
    localparam int          DATA_W   = 8;
    localparam logic [7:0]  MAX_ADDR = 8'hEF;

    // id is sized for the largest supported requester count (8)
    typedef struct packed {
        logic [2:0]        id;
        logic              err;
        logic [DATA_W-1:0] data;
    } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after last_gnt
module rr_arbiter
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
)
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_gnt,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);
    import ram_arb_pkg::*;

    logic [ID_W-1:0] cand;
    logic            found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(last_gnt) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// rtl/ram_access_arbiter.sv - round-robin single-port RAM sharing with address range check
module ram_access_arbiter
#(
    parameter int                NUM_REQ  = 4,
    parameter int                ADDR_W   = ram_arb_pkg::ADDR_W,
    parameter int                DATA_W   = ram_arb_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(ram_arb_pkg::MAX_ADDR),
    parameter int                ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      ram_en,
    output logic                      ram_we,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_wdata,
    input  logic [DATA_W-1:0]         ram_rdata,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_err,
    output logic [DATA_W-1:0]         rsp_data
);
    import ram_arb_pkg::*;

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   last_gnt_q, last_gnt_d;
    logic [ID_W-1:0]   win_q, win_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    rsp_t               rsp;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req      (req_valid),
        .last_gnt (last_gnt_q),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx)
    );

    // One-hot grant lets the payload mux be a plain AND-OR
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_we    = sel_we | req_we[i];
                sel_addr  = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = sel_wdata | req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        win_d      = win_q;
        we_d       = we_q;
        err_d      = err_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    win_d   = gnt_idx;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    err_d   = (sel_addr > MAX_ADDR);
                    state_d = ACCESS;
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                last_gnt_d = win_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        rsp_valid = 1'b0;
        rsp       = '0;
        if (state_q == ACCESS) begin
            req_ready[win_q] = 1'b1;
            if (!err_q) begin
                ram_en    = 1'b1;
                ram_we    = we_q;
                ram_addr  = addr_q;
                ram_wdata = wdata_q;
            end
        end
        if (state_q == RESP) begin
            rsp_valid = 1'b1;
            rsp.id    = 3'(win_q);
            rsp.err   = err_q;
            // rsp_data is the only unregistered path: RAM read data gated in RESP
            if (!err_q && !we_q) begin
                rsp.data = ram_arb_pkg::DATA_W'(ram_rdata);
            end
        end
    end

    assign rsp_id   = ID_W'(rsp.id);
    assign rsp_err  = rsp.err;
    assign rsp_data = DATA_W'(rsp.data);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= ID_W'(NUM_REQ - 1);
            win_q      <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            win_q      <= win_d;
            we_q       <= we_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb/tb_ram_access_arbiter.sv - randomized bench for ram_access_arbiter with transaction-level model
module tb_ram_access_arbiter;

    localparam int         NR   = 4;
    localparam logic [7:0] MAXA = 8'hEF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_we;
    logic [NR*8-1:0] req_addr;
    logic [NR*8-1:0] req_wdata;
    logic [NR-1:0] req_ready;
    logic          ram_en;
    logic          ram_we;
    logic [7:0]    ram_addr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;
    logic          rsp_valid;
    logic [1:0]    rsp_id;
    logic          rsp_err;
    logic [7:0]    rsp_data;

    logic          preload;
    logic [7:0]    mem [256];

    bit            pv  [NR];
    bit            pwe [NR];
    logic [7:0]    pa  [NR];
    logic [7:0]    pd  [NR];

    logic [7:0]    ref_mem [256];
    int            ref_last;
    int            grant_log [$];
    int            n_checks = 0;
    int            n_errors = 0;

    ram_access_arbiter #(
        .NUM_REQ  (NR),
        .ADDR_W   (8),
        .DATA_W   (8),
        .MAX_ADDR (MAXA)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        return (i == 16) ? 8'h5A : 8'((i * 13 + 7) & 255);
    endfunction

    // RAM model: read data is random whenever no read was issued, to expose ungated rsp_data
    always @(posedge clk) begin
        if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
        else                   ram_rdata <= 8'($urandom);
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (ram_en && ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    always_comb begin
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]        = pv[i];
            req_we[i]           = pwe[i];
            req_addr[i*8 +: 8]  = pa[i];
            req_wdata[i*8 +: 8] = pd[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit we, input logic [7:0] a, input logic [7:0] d);
        pv[i] = 1'b1; pwe[i] = we; pa[i] = a; pd[i] = d;
    endtask

    task automatic new_req(input int i);
        logic [7:0] a;
        case ($urandom_range(0, 3))
            0:       a = 8'($urandom_range(0, 15));
            1:       a = MAXA;
            2:       a = 8'($urandom_range(240, 255));
            default: a = 8'($urandom);
        endcase
        set_req(i, 1'($urandom), a, 8'($urandom));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_ram_en"}, 32'(ram_en), 32'd0);
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) pv[i] = 1'b0;
        step();
        check_quiet("reset");
        rst_n    = 1'b1;
        ref_last = NR - 1;
    endtask

    // One arbitration opportunity starting in IDLE; reissue: 0 none, 1 random, 2 all idle requesters
    task automatic txn(input int reissue);
        int         w;
        bit         we, e;
        logic [7:0] a, d, exp_data;
        w = -1;
        for (int k = 1; k <= NR; k++) begin
            int c;
            c = (ref_last + k) % NR;
            if (w < 0 && pv[c]) w = c;
        end
        if (w < 0) begin
            step();
            check("idle_ready", 32'(req_ready), 32'd0);
            check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
            return;
        end
        we = pwe[w]; a = pa[w]; d = pd[w];
        e  = (a > MAXA);
        step();
        pa[w] = 8'($urandom); pd[w] = 8'($urandom); pwe[w] = 1'($urandom);
        pv[w] = 1'b0;
        #1;
        grant_log.push_back(w);
        check("acc_ready", 32'(req_ready), 32'(1 << w));
        check("acc_ram_en", 32'(ram_en), 32'(!e));
        check("acc_ram_we", 32'(ram_we), 32'(e ? 1'b0 : we));
        check("acc_ram_addr", 32'(ram_addr), 32'(e ? 8'h00 : a));
        check("acc_ram_wdata", 32'(ram_wdata), 32'(e ? 8'h00 : d));
        check("acc_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        exp_data = (e || we) ? 8'h00 : ref_mem[a];
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_id", 32'(rsp_id), 32'(w));
        check("rsp_err", 32'(rsp_err), 32'(e));
        check("rsp_data", 32'(rsp_data), 32'(exp_data));
        check("rsp_ready", 32'(req_ready), 32'd0);
        check("rsp_ram_en", 32'(ram_en), 32'd0);
        if (!e && we) ref_mem[a] = d;
        ref_last = w;
        for (int i = 0; i < NR; i++) begin
            if (!pv[i] && (reissue == 2 || (reissue == 1 && $urandom_range(0, 1) == 1))) new_req(i);
        end
        step();
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        preload = 1'b1;
        for (int i = 0; i < NR; i++) begin
            pv[i] = 1'b0; pwe[i] = 1'b0; pa[i] = 8'h00; pd[i] = 8'h00;
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        step();
        step();
        preload = 1'b0;
        do_reset();

        set_req(2, 1'b0, 8'h10, 8'h00); txn(0);
        set_req(0, 1'b1, 8'h20, 8'hC3); txn(0);
        set_req(0, 1'b0, 8'h20, 8'h00); txn(0);
        set_req(1, 1'b0, 8'hF0, 8'h00); txn(0);
        set_req(1, 1'b0, 8'hEF, 8'h00); txn(0);
        set_req(3, 1'b1, 8'hF0, 8'h77); txn(0);
        set_req(3, 1'b1, 8'hEF, 8'h96); txn(0);
        set_req(2, 1'b0, 8'hEF, 8'h00); txn(0);

        do_reset();
        grant_log.delete();
        for (int i = 0; i < NR; i++) new_req(i);
        repeat (8) txn(2);
        for (int k = 0; k < 8; k++) check("fair_order", 32'(grant_log[k]), 32'(k % NR));

        for (int i = 0; i < NR; i++) pv[i] = 1'b0;
        txn(0);
        set_req(3, 1'b0, 8'h05, 8'h00);
        step();
        check("midrst_acc_en", 32'(ram_en), 32'd1);
        check("midrst_acc_ready", 32'(req_ready), 32'h8);
        rst_n = 1'b0;
        pv[3] = 1'b0;
        step();
        check("midrst_ram_en", 32'(ram_en), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        rst_n    = 1'b1;
        ref_last = NR - 1;
        grant_log.delete();
        for (int i = 0; i < NR; i++) new_req(i);
        txn(0);
        check("midrst_first_grant", 32'(grant_log[0]), 32'd0);

        repeat (300) begin
            for (int i = 0; i < NR; i++) begin
                if (!pv[i] && $urandom_range(0, 3) == 0) new_req(i);
            end
            txn(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
